// File: rtl/ps2_key_event_fifo_if.sv
// Handshake bundle for the PS/2 key event buffer.
// Carries the receiver byte channel and the buffered key-event channel.
interface ps2_key_event_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ack;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic       ev_pop;

  modport master (
    output in_valid,
    output in_data,
    output ev_pop,
    input  in_ack,
    input  ev_valid,
    input  ev_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ev_pop,
    output in_ack,
    output ev_valid,
    output ev_data
  );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 scan-code decoder: folds E0/F0 prefixes into key events,
// tracks the held key and press count, and buffers events in a FWFT FIFO.
module ps2_key_event_fifo #(
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_WIDTH     = 8,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  ps2_key_event_fifo_if.slave         bus,
  input  logic                        ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        proto_err,
  output logic [CNT_WIDTH-1:0]        press_count,
  output logic                        held,
  output logic [8:0]                  held_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);
  localparam bit FILTER_EN = (FILTER_REPEAT != 0);

  typedef enum logic {
    IDLE,
    PREFIX
  } state_t;

  state_t state_q, state_d;
  logic   ext_q, ext_d, brk_q, brk_d;
  logic   ack_q;
  logic   sample;
  logic   ev_fire, err_fire;
  logic [9:0] ev_word;

  // The receiver is only sampled when no acknowledge is outstanding, which
  // limits intake to one byte every two cycles.
  assign sample = bus.in_valid & ~ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
    end
  end

  // Prefix bytes accumulate flags in either state; anything else terminates
  // the sequence, and 0x00/0xFF abort it without producing an event.
  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    ev_fire  = 1'b0;
    err_fire = 1'b0;
    ev_word  = {ext_q, brk_q, bus.in_data};
    if (sample) begin
      if (bus.in_data == 8'h00 || bus.in_data == 8'hFF) begin
        err_fire = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
        state_d  = IDLE;
      end else if (bus.in_data == 8'hE0) begin
        ext_d   = 1'b1;
        state_d = PREFIX;
      end else if (bus.in_data == 8'hF0) begin
        brk_d   = 1'b1;
        state_d = PREFIX;
      end else begin
        ev_fire = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        state_d = IDLE;
      end
    end
  end

  logic [8:0] ev_key;
  logic       ev_brk;
  logic       repeat_hit;
  logic       make_acc;
  logic       push;

  assign ev_key     = {ev_word[9], ev_word[7:0]};
  assign ev_brk     = ev_word[8];
  assign repeat_hit = FILTER_EN & held & (held_code == ev_key);
  assign make_acc   = ev_fire & ~ev_brk & ~repeat_hit;
  assign push       = ev_fire & (ev_brk | ~repeat_hit);

  // Press count and held tracking follow accepted makes even when the FIFO
  // has no room for the event itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= '0;
      held        <= 1'b0;
      held_code   <= '0;
    end else if (make_acc) begin
      press_count <= press_count + CNT_WIDTH'(1);
      held        <= 1'b1;
      held_code   <= ev_key;
    end else if (ev_fire && ev_brk && held && held_code == ev_key) begin
      held <= 1'b0;
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   level_q;
  logic [9:0]    head_q;
  logic          empty, full;
  logic          pop_ok, push_ok, drop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LEVEL);
  assign pop_ok  = bus.ev_pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign rd_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= ev_word;
    end
  end

  // head_q is the fall-through output register; it is refilled from the
  // incoming word when that word becomes the new head, and keeps its value
  // once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_next;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + ONE_LEVEL;
        2'b01:   level_q <= level_q - ONE_LEVEL;
        default: level_q <= level_q;
      endcase
      if (push_ok && (empty || (pop_ok && level_q == ONE_LEVEL))) begin
        head_q <= ev_word;
      end else if (pop_ok && level_q > ONE_LEVEL) begin
        head_q <= mem[rd_next];
      end
    end
  end

  // Sticky flags: a new set on the same edge as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (err_fire) begin
        proto_err <= 1'b1;
      end else if (ovf_clr) begin
        proto_err <= 1'b0;
      end
    end
  end

  assign bus.in_ack   = ack_q;
  assign bus.ev_valid = ~empty;
  assign bus.ev_data  = head_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Randomised bench for ps2_key_event_fifo: two configurations driven in
// lockstep and compared every cycle against a queue-based key-event model.
module tb_ps2_key_event_fifo;

  localparam int A_DEPTH = 4;
  localparam int A_CNT   = 4;
  localparam int A_FILT  = 1;
  localparam int B_DEPTH = 8;
  localparam int B_CNT   = 8;
  localparam int B_FILT  = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid;
  logic [7:0] in_data;
  logic       ev_pop;
  logic       ovf_clr;

  ps2_key_event_fifo_if bus_a ();
  ps2_key_event_fifo_if bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.in_data  = in_data;
  assign bus_a.ev_pop   = ev_pop;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_data  = in_data;
  assign bus_b.ev_pop   = ev_pop;

  logic [$clog2(A_DEPTH):0] level_a;
  logic [$clog2(B_DEPTH):0] level_b;
  logic ovf_a, ovf_b, err_a, err_b, held_a, held_b;
  logic [A_CNT-1:0] cnt_a;
  logic [B_CNT-1:0] cnt_b;
  logic [8:0] hc_a, hc_b;

  ps2_key_event_fifo #(.FIFO_DEPTH(A_DEPTH), .CNT_WIDTH(A_CNT), .FILTER_REPEAT(A_FILT)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .ovf_clr(ovf_clr), .fifo_level(level_a),
    .overflow(ovf_a), .proto_err(err_a), .press_count(cnt_a), .held(held_a), .held_code(hc_a)
  );

  ps2_key_event_fifo #(.FIFO_DEPTH(B_DEPTH), .CNT_WIDTH(B_CNT), .FILTER_REPEAT(B_FILT)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .ovf_clr(ovf_clr), .fifo_level(level_b),
    .overflow(ovf_b), .proto_err(err_b), .press_count(cnt_b), .held(held_b), .held_code(hc_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending prefix flags plus, per configuration, a queue of
  // events and the key bookkeeping derived directly from the byte stream.
  bit         m_ack;
  bit         m_ext, m_brk;
  bit         m_err  [2];
  bit         m_ovf  [2];
  int         m_cnt  [2];
  bit         m_held [2];
  logic [8:0] m_hc   [2];
  logic [9:0] m_last [2];
  logic [9:0] mq0 [$];
  logic [9:0] mq1 [$];
  int depth [2] = '{A_DEPTH, B_DEPTH};
  int cmask [2] = '{(1 << A_CNT) - 1, (1 << B_CNT) - 1};
  bit filt  [2] = '{A_FILT != 0, B_FILT != 0};

  function automatic int qsize(int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [9:0] qhead(int i);
    return (i == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qpop(int i);
    if (i == 0) mq0.delete(0);
    else        mq1.delete(0);
  endtask

  task automatic qpush(int i, logic [9:0] w);
    if (i == 0) mq0.push_back(w);
    else        mq1.push_back(w);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_ack = 0; m_ext = 0; m_brk = 0;
    mq0.delete(); mq1.delete();
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
      m_held[i] = 0; m_hc[i] = '0; m_last[i] = '0;
    end
  endtask

  task automatic modelEvent(int i, logic [9:0] w);
    logic [8:0] key;
    key = {w[9], w[7:0]};
    if (!w[8]) begin
      if (filt[i] && m_held[i] && m_hc[i] == key) return;
      m_cnt[i]  = (m_cnt[i] + 1) & cmask[i];
      m_held[i] = 1;
      m_hc[i]   = key;
    end else if (m_held[i] && m_hc[i] == key) begin
      m_held[i] = 0;
    end
    if (qsize(i) < depth[i]) qpush(i, w);
    else                     m_ovf[i] = 1;
  endtask

  task automatic modelByte(logic [7:0] b);
    if (b == 8'h00 || b == 8'hFF) begin
      m_err[0] = 1; m_err[1] = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      for (int i = 0; i < 2; i++) modelEvent(i, {m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("A.in_ack",      bus_a.in_ack,   m_ack);
    checkOutput("A.ev_valid",    bus_a.ev_valid, qsize(0) != 0);
    checkOutput("A.ev_data",     bus_a.ev_data,  m_last[0]);
    checkOutput("A.fifo_level",  level_a,        qsize(0));
    checkOutput("A.overflow",    ovf_a,          m_ovf[0]);
    checkOutput("A.proto_err",   err_a,          m_err[0]);
    checkOutput("A.press_count", cnt_a,          m_cnt[0]);
    checkOutput("A.held",        held_a,         m_held[0]);
    checkOutput("A.held_code",   hc_a,           m_hc[0]);
    checkOutput("B.in_ack",      bus_b.in_ack,   m_ack);
    checkOutput("B.ev_valid",    bus_b.ev_valid, qsize(1) != 0);
    checkOutput("B.ev_data",     bus_b.ev_data,  m_last[1]);
    checkOutput("B.fifo_level",  level_b,        qsize(1));
    checkOutput("B.overflow",    ovf_b,          m_ovf[1]);
    checkOutput("B.proto_err",   err_b,          m_err[1]);
    checkOutput("B.press_count", cnt_b,          m_cnt[1]);
    checkOutput("B.held",        held_b,         m_held[1]);
    checkOutput("B.held_code",   hc_b,           m_hc[1]);
  endtask

  // One clock: apply this cycle's inputs to the model, step the DUTs, compare.
  task automatic tick(output bit sampled);
    logic [7:0] b;
    sampled = in_valid && !m_ack;
    b = in_data;
    for (int i = 0; i < 2; i++) begin
      if (ev_pop && qsize(i) > 0) qpop(i);
      if (ovf_clr) begin
        m_ovf[i] = 0; m_err[i] = 0;
      end
    end
    if (sampled) modelByte(b);
    @(posedge clk);
    #1;
    m_ack = sampled;
    for (int i = 0; i < 2; i++) if (qsize(i) > 0) m_last[i] = qhead(i);
    checkAll();
  endtask

  task automatic doReset();
    in_valid = 0; in_data = '0; ev_pop = 0; ovf_clr = 0;
    rst = 1;
    modelReset();
    #3;
    checkAll();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit pop_at_sample);
    bit s;
    bit got;
    got = 0;
    in_valid = 1; in_data = b; ev_pop = pop_at_sample;
    for (int n = 0; n < 4 && !got; n++) begin
      tick(s);
      got = s;
    end
    checkOutput("byte_accepted", got, 1);
    ev_pop = 0;
    in_valid = $urandom_range(0, 1);
    tick(s);
    in_valid = 0;
  endtask

  task automatic idleTicks(int n, bit rnd);
    bit s;
    for (int k = 0; k < n; k++) begin
      ev_pop  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      ovf_clr = rnd ? ($urandom_range(0, 9) == 0) : 1'b0;
      tick(s);
    end
    ev_pop = 0; ovf_clr = 0;
  endtask

  task automatic drain();
    bit s;
    ev_pop = 1;
    for (int k = 0; k < 20 && (qsize(0) != 0 || qsize(1) != 0); k++) tick(s);
    ev_pop = 0;
    tick(s);
  endtask

  logic [7:0] codes [4] = '{8'h1C, 8'h1D, 8'h75, 8'h12};

  initial begin
    bit s;
    logic [7:0] r;
    doReset();

    // Partial prefix discarded by reset.
    applyStimulus(8'hE0, 0);
    doReset();
    applyStimulus(8'h1C, 0);
    checkOutput("reset_prefix_event", bus_a.ev_data, 10'h01C);
    drain();

    // Make/break and extended keys.
    applyStimulus(8'h1C, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h1C, 0);
    applyStimulus(8'hE0, 0); applyStimulus(8'h75, 0);
    checkOutput("ext_held_code", hc_a, 9'h175);
    applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h75, 0);
    drain();

    // Typematic repeats: filtered in A, kept in B.
    for (int k = 0; k < 4; k++) applyStimulus(8'h1C, 0);
    applyStimulus(8'hF0, 0); applyStimulus(8'h1C, 0);
    checkOutput("repeat_level_A", level_a, 2);
    checkOutput("repeat_level_B", level_b, 5);
    drain();

    // Overflow on the 4-deep configuration.
    doReset();
    for (int k = 0; k < 6; k++) applyStimulus(8'h20 + 8'(k), 0);
    checkOutput("ovf_level_A", level_a, 4);
    checkOutput("ovf_flag_A", ovf_a, 1);
    checkOutput("ovf_count_A", cnt_a, 6);
    checkOutput("ovf_head_A", bus_a.ev_data, 10'h020);
    applyStimulus(8'h30, 1);
    checkOutput("full_pushpop_level_A", level_a, 4);
    ovf_clr = 1; tick(s); ovf_clr = 0;
    checkOutput("ovf_cleared_A", ovf_a, 0);
    drain();

    // Protocol error and counter wrap.
    doReset();
    applyStimulus(8'hFF, 0);
    checkOutput("proto_err_A", err_a, 1);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(8'h40 + 8'(k), 1);
      applyStimulus(8'hF0, 1);
      applyStimulus(8'h40 + 8'(k), 1);
    end
    checkOutput("wrap_count_A", cnt_a, 1);
    drain();

    // Randomised byte streams with pops, clears and one mid-stream reset.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 15))
        0, 1:    r = 8'hE0;
        2, 3:    r = 8'hF0;
        4:       r = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: r = codes[$urandom_range(0, 3)];
      endcase
      applyStimulus(r, 1'($urandom_range(0, 1)));
      idleTicks($urandom_range(0, 2), 1);
      if (k == 150) doReset();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
